// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one unified memory bus.
//   Build option: define ARB_ROUND_ROBIN_EN for alternating grants on conflict; otherwise data always wins.
//   Ports:
//     Clk, Reset_N                    clock and asynchronous active-low reset
//     i_req, i_address                fetch request (held until i_ready)
//     i_rdata, i_ready                fetched word and one-cycle completion pulse
//     d_readM, d_writeM, d_address,   data request (held until d_ready); write wins if both set
//     d_wdata
//     d_rdata, d_ready                load data and one-cycle completion pulse
//     m_readM, m_writeM, m_address,   unified-memory strobes, address and store data
//     m_wdata
//     m_rdata, m_ack                  unified-memory read data and completion pulse
//     grant_count                     completed memory transactions (wraps)
module mem_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ack,
  output logic [WORD_SIZE-1:0] grant_count
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  logic [1:0] state;
  logic d_req, pick_d;
  assign d_req = d_readM | d_writeM;
`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant record: 1 = data was granted last; reset points at fetch so data wins the first conflict.
  logic last_d;
  assign pick_d = d_req & (~i_req | ~last_d);
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) last_d <= 1'b0;
    else if (state == IDLE && (d_req | i_req)) last_d <= pick_d;
`else
  assign pick_d = d_req;
`endif
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      state       <= IDLE;
      m_readM     <= 1'b0;
      m_writeM    <= 1'b0;
      m_address   <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      grant_count <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (state == IDLE) begin
        if (d_req | i_req) begin
          state     <= pick_d ? D_BUSY : I_BUSY;
          m_address <= pick_d ? d_address : i_address;
          m_wdata   <= pick_d ? d_wdata : m_wdata;
          m_writeM  <= pick_d & d_writeM;
          m_readM   <= ~(pick_d & d_writeM);
        end
      end else if (m_ack) begin
        state       <= IDLE;
        m_readM     <= 1'b0;
        m_writeM    <= 1'b0;
        grant_count <= grant_count + WORD_SIZE'(1);
        if (state == I_BUSY) begin
          i_ready <= 1'b1;
          i_rdata <= m_rdata;
        end else begin
          d_ready <= 1'b1;
          d_rdata <= m_readM ? m_rdata : d_rdata;
        end
      end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, address and data width of every bus.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset_N  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch read request; held until i_ready.
REQ-005 i_address  input  WORD_SIZE  fetch address.
REQ-006 i_rdata  output  WORD_SIZE  fetched word; valid while i_ready=1.
REQ-007 i_ready  output  1  one-cycle fetch completion pulse.
REQ-008 d_readM  input  1  data read request; held until d_ready.
REQ-009 d_writeM  input  1  data write request; held until d_ready.
REQ-010 d_address  input  WORD_SIZE  data address.
REQ-011 d_wdata  input  WORD_SIZE  store data.
REQ-012 d_rdata  output  WORD_SIZE  load data; valid while d_ready=1.
REQ-013 d_ready  output  1  one-cycle data completion pulse (read or write).
REQ-014 m_readM  output  1  unified-memory read strobe.
REQ-015 m_writeM  output  1  unified-memory write strobe.
REQ-016 m_address  output  WORD_SIZE  unified-memory address.
REQ-017 m_wdata  output  WORD_SIZE  unified-memory write data.
REQ-018 m_rdata  input  WORD_SIZE  unified-memory read data, valid with m_ack.
REQ-019 m_ack  input  1  memory completion, one cycle, arbitrary latency >=1 cycle after strobe.
REQ-020 grant_count  output  WORD_SIZE  number of completed memory transactions.

Function
REQ-021 The block SHALL implement states IDLE, I_BUSY, D_BUSY, all outputs registered.
REQ-022 In IDLE with a pending request, the block SHALL latch address/data/direction and enter I_BUSY or D_BUSY; strobe asserts the following cycle.
REQ-023 In IDLE with no request, the block SHALL stay in IDLE with both strobes low.
REQ-024 When i_req and a data request are both pending in IDLE, grant SHALL follow the arbitration rule of REQ-039/REQ-040.
REQ-025 When d_readM and d_writeM are both high, the block SHALL perform a write.
REQ-026 In a BUSY state, m_readM or m_writeM (exactly one) SHALL stay high with stable m_address/m_wdata until the cycle m_ack=1.
REQ-027 On m_ack in I_BUSY, the next cycle SHALL have i_ready=1, i_rdata=m_rdata captured at ack, strobes low, state IDLE.
REQ-028 On m_ack in D_BUSY, the next cycle SHALL have d_ready=1 (d_rdata=captured m_rdata for reads, unchanged for writes), strobes low, state IDLE.
REQ-029 Requester inputs changing during BUSY SHALL NOT affect the in-flight transaction.
REQ-030 m_ack while IDLE SHALL be ignored.
REQ-031 A request still asserted in the ready cycle SHALL be arbitrated in that IDLE cycle as a new transaction; minimum issue interval is 3 cycles for 1-cycle memory latency.
REQ-032 grant_count SHALL increment by 1 on each m_ack accepted in a BUSY state, wrapping 16'hFFFF to 0.
REQ-033 i_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-034 Reset_N=0 SHALL immediately force state IDLE, m_readM=0, m_writeM=0, i_ready=0, d_ready=0.
REQ-035 Reset SHALL clear m_address, m_wdata, i_rdata, d_rdata, grant_count to 0 and the last-grant record to I.
REQ-036 Reset mid-transaction SHALL drop the transaction; a late m_ack after release SHALL be ignored per REQ-030.
REQ-037 After Reset_N rises, the first arbitration SHALL occur on the first rising Clk edge.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN SHALL select the conflict rule.
REQ-039 Without ARB_ROUND_ROBIN_EN, a data request SHALL always win over i_req.
REQ-040 With ARB_ROUND_ROBIN_EN, on conflict the requester not granted last SHALL win; after reset data wins first; uncontested grants update the record.

Verification
REQ-041 i_req, i_address=16'h0010, memory ack 2 cycles after strobe, m_rdata=16'hABCD -> m_readM 2 cycles, i_ready 1 cycle with i_rdata=16'hABCD, grant_count=1.
REQ-042 d_writeM, d_address=16'h0100, d_wdata=16'h1234, 1-cycle ack -> m_writeM with m_address=16'h0100, m_wdata=16'h1234, d_ready pulse, i_ready stays 0.
REQ-043 i_req and d_readM held continuously, macro off -> only d_ready pulses, i_req starved; macro on -> d_ready and i_ready alternate starting with d_ready.
REQ-044 Reset_N pulsed low during D_BUSY, then m_ack one cycle after release -> strobes drop asynchronously, no d_ready, grant_count=0.
REQ-045 d_readM and d_writeM both high -> m_writeM=1, m_readM=0 throughout.
REQ-046 grant_count preloaded to 16'hFFFF via 65535 one-cycle transactions, one more ack -> grant_count=16'h0000.
